// File: rtl/lsu.sv
// Load/store unit between execute and a big-endian, byte-addressed data memory.
// Define LSU_MISALIGN_EN to split misaligned 2/4-byte accesses into byte accesses.
module lsu (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_addr,
    output logic [2:0]  o_mem_insize,
    output logic        o_mem_insign,
    output logic [2:0]  o_mem_outsize,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
`ifdef LSU_MISALIGN_EN
        SPLIT,
`endif
        DONE
    } state_t;

    state_t state;
    logic   we_q;

    function automatic logic size_legal(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
    endfunction

    function automatic logic is_aligned(input logic [2:0] s, input logic [31:0] a);
        case (s)
            3'd2:    return ~a[0];
            3'd4:    return (a[1:0] == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

`ifdef LSU_MISALIGN_EN
    logic [2:0]  size_q;
    logic        sign_q;
    logic [31:0] wdata_q;
    logic [31:0] acc;
    logic [1:0]  k;
    logic [2:0]  field_idx;
    logic [31:0] next_acc;
    logic [31:0] ext_acc;
    logic        last;

    // Byte k of a big-endian access lives in field (size-1-k) of the right-justified word.
    function automatic logic [7:0] byte_field(input logic [31:0] d, input logic [2:0] s,
                                              input logic [1:0] kk);
        logic [2:0] idx;
        idx = s - 3'd1 - {1'b0, kk};
        return d[{idx[1:0], 3'b000} +: 8];
    endfunction

    always_comb begin
        field_idx = size_q - 3'd1 - {1'b0, k};
        next_acc  = acc | ({24'h0, i_mem_rdata[7:0]} << {field_idx[1:0], 3'b000});
        last      = ({1'b0, k} == (size_q - 3'd1));
        ext_acc   = (sign_q && (size_q == 3'd2)) ? {{16{next_acc[15]}}, next_acc[15:0]}
                                                 : next_acc;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            o_ready       <= 1'b1;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_rdata       <= 32'h0;
            o_mem_addr    <= 32'h0;
            o_mem_insize  <= 3'd0;
            o_mem_insign  <= 1'b0;
            o_mem_outsize <= 3'd0;
            o_mem_wdata   <= 32'h0;
`ifdef LSU_MISALIGN_EN
            size_q        <= 3'd0;
            sign_q        <= 1'b0;
            wdata_q       <= 32'h0;
            acc           <= 32'h0;
            k             <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req) begin
                        we_q    <= i_we;
                        o_ready <= 1'b0;
`ifdef LSU_MISALIGN_EN
                        size_q  <= i_size;
                        sign_q  <= i_sign;
                        wdata_q <= i_wdata;
`endif
                        if (!size_legal(i_size)) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
                        end else if (is_aligned(i_size, i_addr)) begin
                            state      <= ACCESS;
                            o_mem_addr <= i_addr;
                            if (i_we) begin
                                o_mem_outsize <= i_size;
                                o_mem_wdata   <= i_wdata;
                            end else begin
                                o_mem_insize <= i_size;
                                o_mem_insign <= i_sign;
                            end
                        end else begin
`ifdef LSU_MISALIGN_EN
                            state      <= SPLIT;
                            k          <= 2'd0;
                            acc        <= 32'h0;
                            o_mem_addr <= i_addr;
                            if (i_we) begin
                                o_mem_outsize <= 3'd1;
                                o_mem_wdata   <= {24'h0, byte_field(i_wdata, i_size, 2'd0)};
                            end else begin
                                o_mem_insize <= 3'd1;
                                o_mem_insign <= 1'b0;
                            end
`else
                            state  <= DONE;
                            o_done <= 1'b1;
                            o_err  <= 1'b1;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q)
                        o_rdata <= i_mem_rdata;
                    o_mem_addr    <= 32'h0;
                    o_mem_insize  <= 3'd0;
                    o_mem_insign  <= 1'b0;
                    o_mem_outsize <= 3'd0;
                    o_mem_wdata   <= 32'h0;
                    state         <= DONE;
                    o_done        <= 1'b1;
                    o_err         <= 1'b0;
                end
`ifdef LSU_MISALIGN_EN
                SPLIT: begin
                    if (last) begin
                        if (!we_q)
                            o_rdata <= ext_acc;
                        o_mem_addr    <= 32'h0;
                        o_mem_insize  <= 3'd0;
                        o_mem_insign  <= 1'b0;
                        o_mem_outsize <= 3'd0;
                        o_mem_wdata   <= 32'h0;
                        state         <= DONE;
                        o_done        <= 1'b1;
                        o_err         <= 1'b0;
                    end else begin
                        acc         <= next_acc;
                        k           <= k + 2'd1;
                        o_mem_addr  <= o_mem_addr + 32'd1;
                        o_mem_wdata <= {24'h0, byte_field(wdata_q, size_q, k + 2'd1)};
                    end
                end
`endif
                DONE: begin
                    state   <= IDLE;
                    o_done  <= 1'b0;
                    o_err   <= 1'b0;
                    o_ready <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    o_done  <= 1'b0;
                    o_err   <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu with a behavioural big-endian memory attached.
// Expected results are directed, hand-computed values; a monitor checks each done pulse.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  size = 3'd0;
    logic        sign = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, err;
    logic [31:0] rdata, memAddr, memWdata, memRdata;
    logic [2:0]  memInSize, memOutSize;
    logic        memInSign;

    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  ra;
    logic [7:0]  wa;
    int          writeCount = 0;
    int          cycle = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] lastRdata = 32'h0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          doneCycle;
        string       name;
    } exp_t;
    exp_t sbQueue[$];
    exp_t monExp;

    lsu dut (
        .i_clk(clk), .i_rst_n(rstN), .i_req(req), .i_we(we), .i_size(size),
        .i_sign(sign), .i_addr(addr), .i_wdata(wdata), .o_ready(ready),
        .o_done(done), .o_err(err), .o_rdata(rdata), .o_mem_addr(memAddr),
        .o_mem_insize(memInSize), .o_mem_insign(memInSign),
        .o_mem_outsize(memOutSize), .o_mem_wdata(memWdata), .i_mem_rdata(memRdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Memory model: combinational big-endian read, write on the rising edge.
    always_comb begin
        ra       = memAddr[7:0];
        memRdata = 32'h0;
        case (memInSize)
            3'd1: memRdata = memInSign ? {{24{mem[ra][7]}}, mem[ra]} : {24'h0, mem[ra]};
            3'd2: memRdata = memInSign ? {{16{mem[ra][7]}}, mem[ra], mem[ra + 8'd1]}
                                       : {16'h0, mem[ra], mem[ra + 8'd1]};
            3'd4: memRdata = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
            default: memRdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        wa = memAddr[7:0];
        case (memOutSize)
            3'd1: mem[wa] <= memWdata[7:0];
            3'd2: begin
                mem[wa]        <= memWdata[15:8];
                mem[wa + 8'd1] <= memWdata[7:0];
            end
            3'd4: begin
                mem[wa]        <= memWdata[31:24];
                mem[wa + 8'd1] <= memWdata[23:16];
                mem[wa + 8'd2] <= memWdata[15:8];
                mem[wa + 8'd3] <= memWdata[7:0];
            end
            default: ;
        endcase
        if (memOutSize != 3'd0)
            writeCount <= writeCount + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (rstN && done) begin
            if (sbQueue.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no completion");
            end else begin
                monExp = sbQueue.pop_front();
                checkOutput({monExp.name, " err"}, {31'h0, err}, {31'h0, monExp.err});
                checkOutput({monExp.name, " rdata"}, rdata, monExp.rdata);
                checkOutput({monExp.name, " done_cycle"}, 32'(cycle), 32'(monExp.doneCycle));
                checkOutput({monExp.name, " outsize_in_done"}, {29'h0, memOutSize}, 32'h0);
            end
        end
    end

    task automatic applyStimulus(input string name, input logic w, input logic [2:0] s,
                                 input logic sg, input logic [31:0] a, input logic [31:0] d,
                                 input logic expErr, input logic [31:0] expRdata,
                                 input int latency);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s ready_timeout: got ready=0, expected 1", name);
        end
        req = 1'b1; we = w; size = s; sign = sg; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sbQueue.push_back('{expErr, expRdata, cycle + latency - 1, name});
        req = 1'b0; we = ~w; size = 3'd7; sign = ~sg; addr = ~a; wdata = ~d;
        n = 0;
        while (sbQueue.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sbQueue.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s done_timeout: got no done, expected done", name);
            sbQueue.delete();
        end
        lastRdata = expRdata;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wc;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ready", {31'h0, ready}, 32'h1);
        checkOutput("reset done", {31'h0, done}, 32'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        checkOutput("reset outsize", {29'h0, memOutSize}, 32'h0);
        checkOutput("reset memaddr", memAddr, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus("st4_aligned", 1'b1, 3'd4, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, lastRdata, 2);
        applyStimulus("ld1_sign", 1'b0, 3'd1, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFFDE, 2);

        // Reset arrives while an aligned store sits in ACCESS.
        @(negedge clk);
        wc = writeCount;
        req = 1'b1; we = 1'b1; size = 3'd4; sign = 1'b0; addr = 32'h10; wdata = 32'h01020304;
        @(posedge clk);
        #1;
        req = 1'b0;
        checkOutput("rst_mid access_outsize", {29'h0, memOutSize}, 32'h4);
        rstN = 1'b0;
        #1;
        checkOutput("rst_mid outsize", {29'h0, memOutSize}, 32'h0);
        checkOutput("rst_mid ready", {31'h0, ready}, 32'h1);
        checkOutput("rst_mid rdata", rdata, 32'h0);
        lastRdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("rst_mid no_write", 32'(writeCount - wc), 32'h0);
        checkOutput("rst_mid mem10", {24'h0, mem[8'h10]}, 32'hDE);

        applyStimulus("ld2_unsigned", 1'b0, 3'd2, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0000BEEF, 2);
        applyStimulus("ld2_signed", 1'b0, 3'd2, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFBEEF, 2);

        wc = writeCount;
        applyStimulus("illegal_size", 1'b1, 3'd3, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, lastRdata, 1);
        checkOutput("illegal_size writes", 32'(writeCount - wc), 32'h0);

        applyStimulus("st2_aligned", 1'b1, 3'd2, 1'b0, 32'h30, 32'h1234ABCD, 1'b0, lastRdata, 2);
        applyStimulus("st1_aligned", 1'b1, 3'd1, 1'b0, 32'h33, 32'h00000077, 1'b0, lastRdata, 2);
        applyStimulus("ld4_aligned", 1'b0, 3'd4, 1'b0, 32'h30, 32'h0, 1'b0, 32'hABCD0077, 2);

        wc = writeCount;
`ifdef LSU_MISALIGN_EN
        applyStimulus("st4_split", 1'b1, 3'd4, 1'b0, 32'h21, 32'h11223344, 1'b0, lastRdata, 5);
        checkOutput("st4_split writes", 32'(writeCount - wc), 32'h4);
        checkOutput("st4_split bytes", {mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]},
                    32'h11223344);
        applyStimulus("ld4_after_split", 1'b0, 3'd4, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00112233, 2);
        applyStimulus("ld2_split_sign", 1'b0, 3'd2, 1'b1, 32'h11, 32'h0, 1'b0, 32'hFFFFADBE, 3);
        applyStimulus("ld4_split", 1'b0, 3'd4, 1'b0, 32'h0F, 32'h0, 1'b0, 32'h00DEADBE, 5);
        applyStimulus("st2_wrap", 1'b1, 3'd2, 1'b0, 32'hFFFFFFFF, 32'h00005AA5, 1'b0, lastRdata, 3);
        checkOutput("st2_wrap bytes", {16'h0, mem[8'hFF], mem[8'h00]}, 32'h00005AA5);
`else
        applyStimulus("st4_misaligned", 1'b1, 3'd4, 1'b0, 32'h21, 32'h11223344, 1'b1, lastRdata, 1);
        checkOutput("st4_misaligned writes", 32'(writeCount - wc), 32'h0);
        checkOutput("st4_misaligned bytes", {mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24]},
                    32'h0);
        applyStimulus("ld4_after_misaligned", 1'b0, 3'd4, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 2);
        applyStimulus("ld2_misaligned", 1'b0, 3'd2, 1'b1, 32'h11, 32'h0, 1'b1, lastRdata, 1);
        wc = writeCount;
        applyStimulus("st2_wrap", 1'b1, 3'd2, 1'b0, 32'hFFFFFFFF, 32'h00005AA5, 1'b1, lastRdata, 1);
        checkOutput("st2_wrap writes", 32'(writeCount - wc), 32'h0);
        checkOutput("st2_wrap bytes", {16'h0, mem[8'hFF], mem[8'h00]}, 32'h0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
